stage3_ex: RTL and testbench
============================

Name: stage3_ex

Overview:
- Execute stage plus EX/MEM pipeline register of the 5-stage RV32I core.
- Consumes the ID/EX register outputs: control, RD1E/RD2E, rd, ImmExtE, pce, funct3E.
- Performs operand forwarding, ALU operation, branch/jump resolution and target calculation.
- Registers results for the memory stage; redirect signals to fetch are combinational.

Parameters:
- DATA_WIDTH, 32, datapath width.
- RESET_PC_TARGET, 32'h0, value driven on PCTargetE while the stage holds a bubble.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- ValidE  in  1  ID/EX slot holds a real instruction.
- RegWriteE  in  1  register-file write enable.
- ResultSrcE  in  2  writeback select (00 ALU, 01 mem, 10 PC+4).
- MemWriteE  in  1  store enable.
- ALUctrlE  in  4  ALU opcode.
- ALUSrcE  in  1  0 selects the forwarded RD2 path; 1 selects ImmExtE.
- BranchE  in  1  conditional branch.
- JumpE  in  1  JAL/JALR.
- JalrE  in  1  target is ALU result with bit 0 cleared.
- RD1E, RD2E  in  DATA_WIDTH  register operands.
- RdE  in  5  destination register.
- ImmExtE  in  DATA_WIDTH  immediate.
- pce  in  DATA_WIDTH  instruction PC.
- funct3E  in  3  branch / load-store width.
- ForwardAE, ForwardBE  in  2  00 regfile, 01 ResultW, 10 ALUResultM.
- ResultW  in  DATA_WIDTH  writeback value.
- StallM  in  1  hold the EX/MEM register.
- PCSrcE  out  1  redirect fetch; combinational.
- PCTargetE  out  DATA_WIDTH  redirect target; combinational.
- BusyE  out  1  multi-cycle op in progress; upstream must stall.
- ValidM, RegWriteM, MemWriteM  out  1  registered control.
- ResultSrcM  out  2  registered writeback select.
- ALUResultM, WriteDataM, PCPlus4M  out  DATA_WIDTH  registered data.
- RdM  out  5  registered destination.
- funct3M  out  3  registered funct3.

Behaviour:
- Reset: every registered output is 0 (ValidM=0, RegWriteM=0, MemWriteM=0, data 0). Multiplier FSM goes to IDLE. BusyE=0.
- Operand muxes: SrcA = fwd(RD1E, ForwardAE). WriteData = fwd(RD2E, ForwardBE). SrcB = ALUSrcE ? ImmExtE : WriteData. Forward code 11 behaves as 00.
- ALU opcodes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR.
  - 0101 SLT (signed), 0110 SLTU.
  - 0111 SLL, 1000 SRL, 1001 SRA; shift amount is SrcB[4:0].
  - 1010 pass SrcB (LUI).
  - 1011 MUL, available only with the optional feature.
  - Unused codes produce 0.
- Branch resolution, funct3E: 000 EQ, 001 NE, 100 LT, 101 GE, 110 LTU, 111 GEU; other codes mean not taken.
- PCSrcE = ValidE & (JumpE | (BranchE & cond)). Qualified by ValidE only; not gated by BusyE or StallM.
- PCTargetE = JalrE ? (ALUResult & ~1) : pce + ImmExtE. Equals RESET_PC_TARGET when ValidE=0.
- PCPlus4 = pce + 4, wrapping modulo 2^DATA_WIDTH.
- EX/MEM register, latency 1 cycle. Priority per clock edge:
  1. rst: clear everything.
  2. StallM: hold all outputs.
  3. BusyE: load a bubble (ValidM=0, RegWriteM=0, MemWriteM=0; data don't-care, drive 0).
  4. Otherwise: load ALU/control values. RegWriteM and MemWriteM are ANDed with ValidE.
- StallM together with a redirect: PCSrcE still asserts. The upstream hazard unit is responsible for flush ordering.

Optional Feature:
- Macro: RV32_MUL_EN.
- Defined: ALUctrl 1011 starts a 32-iteration shift-add multiplier producing the low 32 bits. FSM:
  - IDLE → BUSY when ValidE & op==1011 & !StallM.
  - BUSY counts 31..0; BusyE=1 throughout BUSY.
  - BUSY → DONE at count 0.
  - DONE: BusyE=0; the product loads into ALUResultM; → IDLE.
  - Latency: 33 cycles from issue to ALUResultM.
  - Operands are captured at issue, so ForwardAE/BE may change during BUSY.
  - StallM in DONE holds the FSM in DONE.
  - rst mid-operation returns the FSM to IDLE immediately.
- Undefined: 1011 yields 0, BusyE is tied to 0, and no FSM is instantiated.

Decomposition:
- Package core_pkg:
  - alu_op_e enum (4-bit codes above).
  - fwd_sel_e (00/01/10).
  - result_src_e.
  - branch funct3 constants.
- Sub-module seq_mul (multiplier FSM), instantiated under RV32_MUL_EN.
- ALU and branch compare are kept inline.

Test Plan:
- Reset: rst=1 for 2 cycles → all M outputs 0, BusyE=0. Release, then ADD 5+7 with ValidE=1 → next cycle ALUResultM=12, ValidM=1.
- Forwarding: RD1E=1, ForwardAE=10, prior ALUResultM=100, SUB with Imm=30 → ALUResultM=70. Repeat with ForwardAE=01, ResultW=9 → ALUResultM=-21 (0xFFFFFFEB).
- Branch: BLT with SrcA=-1, SrcB=1, pce=0x100, Imm=0x20 → PCSrcE=1, PCTargetE=0x120. BLTU with the same operands → PCSrcE=0. JALR with SrcA=0x203, Imm=0 → target 0x202, PCPlus4M=pce+4.
- Stall: StallM=1 for 3 cycles during ADD issue → M outputs hold the previous values. On release the new result appears one cycle later.
- Bubble: ValidE=0 with RegWriteE=1, MemWriteE=1 → RegWriteM=0, MemWriteM=0, PCSrcE=0 even with JumpE=1.
- (RV32_MUL_EN) MUL 0xFFFF×0x10001:
  - BusyE=1 for cycles 1–32; ValidM=0 during busy.
  - ALUResultM=0xFFFFFFFF at cycle 33.
  - rst asserted at cycle 10 → BusyE=0 next cycle and the FSM is back in IDLE.

Source files
------------

// File: rtl/core_pkg.sv
// Shared encodings for the RV32I execute stage: ALU opcodes, forwarding
// selects, writeback selects, branch funct3 codes and multiplier states.
package core_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SUB  = 4'b0001,
        ALU_AND  = 4'b0010,
        ALU_OR   = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SLT  = 4'b0101,
        ALU_SLTU = 4'b0110,
        ALU_SLL  = 4'b0111,
        ALU_SRL  = 4'b1000,
        ALU_SRA  = 4'b1001,
        ALU_LUI  = 4'b1010,
        ALU_MUL  = 4'b1011
    } alu_op_e;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        RES_ALU = 2'b00,
        RES_MEM = 2'b01,
        RES_PC4 = 2'b10
    } result_src_e;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'b00,
        MUL_BUSY = 2'b01,
        MUL_DONE = 2'b10
    } mul_state_e;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/stage3_ex_seq_mul.sv
// Iterative shift-add multiplier producing the low DATA_WIDTH bits of a*b.
// One partial product per cycle in BUSY; result presented in DONE.
module seq_mul
    import core_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  stall,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] product
);

    localparam int unsigned CNT_W = $clog2(DATA_WIDTH);

    mul_state_e            state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
    logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;

    // State and datapath registers; reset abandons any operation in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= MUL_IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
        end
    end

    // Next-state: capture operands at issue, then one shift-add step per cycle.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        unique case (state_q)
            MUL_IDLE: begin
                if (start) begin
                    mcand_d  = op_a;
                    mplier_d = op_b;
                    acc_d    = '0;
                    cnt_d    = CNT_W'(DATA_WIDTH - 1);
                    state_d  = MUL_BUSY;
                end
            end
            MUL_BUSY: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + mcand_q;
                end
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q - 1'b1;
                if (cnt_q == '0) begin
                    state_d = MUL_DONE;
                end
            end
            MUL_DONE: begin
                if (!stall) begin
                    state_d = MUL_IDLE;
                end
            end
            default: state_d = MUL_IDLE;
        endcase
    end

    // Busy also covers the issue cycle so the ID/EX slot keeps the MUL
    // (and its rd/control) until DONE writes the product back.
    always_comb begin
        busy    = !rst && ((state_q == MUL_IDLE && start) || state_q == MUL_BUSY);
        done    = (state_q == MUL_DONE);
        product = acc_q;
    end

endmodule

// File: rtl/stage3_ex.sv
// Execute stage and EX/MEM pipeline register of the 5-stage RV32I core.
// Optional sequential multiplier enabled by defining RV32_MUL_EN.
module stage3_ex
    import core_pkg::*;
#(
    parameter int unsigned                 DATA_WIDTH      = 32,
    parameter logic [DATA_WIDTH-1:0]       RESET_PC_TARGET = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ValidE,
    input  logic                  RegWriteE,
    input  logic [1:0]            ResultSrcE,
    input  logic                  MemWriteE,
    input  logic [3:0]            ALUctrlE,
    input  logic                  ALUSrcE,
    input  logic                  BranchE,
    input  logic                  JumpE,
    input  logic                  JalrE,
    input  logic [DATA_WIDTH-1:0] RD1E,
    input  logic [DATA_WIDTH-1:0] RD2E,
    input  logic [4:0]            RdE,
    input  logic [DATA_WIDTH-1:0] ImmExtE,
    input  logic [DATA_WIDTH-1:0] pce,
    input  logic [2:0]            funct3E,
    input  logic [1:0]            ForwardAE,
    input  logic [1:0]            ForwardBE,
    input  logic [DATA_WIDTH-1:0] ResultW,
    input  logic                  StallM,
    output logic                  PCSrcE,
    output logic [DATA_WIDTH-1:0] PCTargetE,
    output logic                  BusyE,
    output logic                  ValidM,
    output logic                  RegWriteM,
    output logic                  MemWriteM,
    output logic [1:0]            ResultSrcM,
    output logic [DATA_WIDTH-1:0] ALUResultM,
    output logic [DATA_WIDTH-1:0] WriteDataM,
    output logic [DATA_WIDTH-1:0] PCPlus4M,
    output logic [4:0]            RdM,
    output logic [2:0]            funct3M
);

    logic [DATA_WIDTH-1:0] src_a, src_b, write_data;
    logic [DATA_WIDTH-1:0] alu_result, alu_result_ex, pc_plus4;
    logic [4:0]            shamt;
    logic                  branch_cond;
    logic                  busy;

    logic                  valid_m_q, valid_m_d;
    logic                  reg_write_m_q, reg_write_m_d;
    logic                  mem_write_m_q, mem_write_m_d;
    logic [1:0]            result_src_m_q, result_src_m_d;
    logic [DATA_WIDTH-1:0] alu_result_m_q, alu_result_m_d;
    logic [DATA_WIDTH-1:0] write_data_m_q, write_data_m_d;
    logic [DATA_WIDTH-1:0] pc_plus4_m_q, pc_plus4_m_d;
    logic [4:0]            rd_m_q, rd_m_d;
    logic [2:0]            funct3_m_q, funct3_m_d;

    function automatic logic [DATA_WIDTH-1:0] fwd(
        input logic [DATA_WIDTH-1:0] rf,
        input logic [1:0]            sel,
        input logic [DATA_WIDTH-1:0] wb,
        input logic [DATA_WIDTH-1:0] mem
    );
        case (fwd_sel_e'(sel))
            FWD_WB:  return wb;
            FWD_MEM: return mem;
            default: return rf;
        endcase
    endfunction

    // Operand selection with forwarding from MEM and WB.
    always_comb begin
        src_a      = fwd(RD1E, ForwardAE, ResultW, alu_result_m_q);
        write_data = fwd(RD2E, ForwardBE, ResultW, alu_result_m_q);
        src_b      = ALUSrcE ? ImmExtE : write_data;
    end

    // Single-cycle ALU; MUL and unused codes yield 0 here.
    always_comb begin
        alu_result = '0;
        shamt      = src_b[4:0];
        case (alu_op_e'(ALUctrlE))
            ALU_ADD:  alu_result = src_a + src_b;
            ALU_SUB:  alu_result = src_a - src_b;
            ALU_AND:  alu_result = src_a & src_b;
            ALU_OR:   alu_result = src_a | src_b;
            ALU_XOR:  alu_result = src_a ^ src_b;
            ALU_SLT:  alu_result = {{(DATA_WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
            ALU_SLTU: alu_result = {{(DATA_WIDTH-1){1'b0}}, src_a < src_b};
            ALU_SLL:  alu_result = src_a << shamt;
            ALU_SRL:  alu_result = src_a >> shamt;
            ALU_SRA:  alu_result = $unsigned($signed(src_a) >>> shamt);
            ALU_LUI:  alu_result = src_b;
            default:  alu_result = '0;
        endcase
    end

    // Branch condition from the forwarded operands.
    always_comb begin
        branch_cond = 1'b0;
        case (funct3E)
            F3_BEQ:  branch_cond = (src_a == src_b);
            F3_BNE:  branch_cond = (src_a != src_b);
            F3_BLT:  branch_cond = ($signed(src_a) <  $signed(src_b));
            F3_BGE:  branch_cond = ($signed(src_a) >= $signed(src_b));
            F3_BLTU: branch_cond = (src_a <  src_b);
            F3_BGEU: branch_cond = (src_a >= src_b);
            default: branch_cond = 1'b0;
        endcase
    end

    // Redirect to fetch; qualified only by ValidE.
    always_comb begin
        pc_plus4 = pce + DATA_WIDTH'(4);
        PCSrcE   = ValidE & (JumpE | (BranchE & branch_cond));
        if (!ValidE) begin
            PCTargetE = RESET_PC_TARGET;
        end else if (JalrE) begin
            PCTargetE = {alu_result[DATA_WIDTH-1:1], 1'b0};
        end else begin
            PCTargetE = pce + ImmExtE;
        end
    end

`ifdef RV32_MUL_EN
    logic                  mul_start;
    logic                  mul_done;
    logic [DATA_WIDTH-1:0] mul_product;

    assign mul_start = ValidE & (ALUctrlE == ALU_MUL) & ~StallM;

    seq_mul #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_seq_mul (
        .clk    (clk),
        .rst    (rst),
        .start  (mul_start),
        .stall  (StallM),
        .op_a   (src_a),
        .op_b   (src_b),
        .busy   (busy),
        .done   (mul_done),
        .product(mul_product)
    );

    assign alu_result_ex = mul_done ? mul_product : alu_result;
`else
    assign busy          = 1'b0;
    assign alu_result_ex = alu_result;
`endif

    assign BusyE = busy;

    // EX/MEM next value: stall holds, busy inserts a bubble, else load.
    always_comb begin
        valid_m_d      = valid_m_q;
        reg_write_m_d  = reg_write_m_q;
        mem_write_m_d  = mem_write_m_q;
        result_src_m_d = result_src_m_q;
        alu_result_m_d = alu_result_m_q;
        write_data_m_d = write_data_m_q;
        pc_plus4_m_d   = pc_plus4_m_q;
        rd_m_d         = rd_m_q;
        funct3_m_d     = funct3_m_q;
        if (StallM) begin
            // hold
        end else if (busy) begin
            valid_m_d      = 1'b0;
            reg_write_m_d  = 1'b0;
            mem_write_m_d  = 1'b0;
            result_src_m_d = '0;
            alu_result_m_d = '0;
            write_data_m_d = '0;
            pc_plus4_m_d   = '0;
            rd_m_d         = '0;
            funct3_m_d     = '0;
        end else begin
            valid_m_d      = ValidE;
            reg_write_m_d  = RegWriteE & ValidE;
            mem_write_m_d  = MemWriteE & ValidE;
            result_src_m_d = ResultSrcE;
            alu_result_m_d = alu_result_ex;
            write_data_m_d = write_data;
            pc_plus4_m_d   = pc_plus4;
            rd_m_d         = RdE;
            funct3_m_d     = funct3E;
        end
    end

    // EX/MEM register with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_m_q      <= 1'b0;
            reg_write_m_q  <= 1'b0;
            mem_write_m_q  <= 1'b0;
            result_src_m_q <= '0;
            alu_result_m_q <= '0;
            write_data_m_q <= '0;
            pc_plus4_m_q   <= '0;
            rd_m_q         <= '0;
            funct3_m_q     <= '0;
        end else begin
            valid_m_q      <= valid_m_d;
            reg_write_m_q  <= reg_write_m_d;
            mem_write_m_q  <= mem_write_m_d;
            result_src_m_q <= result_src_m_d;
            alu_result_m_q <= alu_result_m_d;
            write_data_m_q <= write_data_m_d;
            pc_plus4_m_q   <= pc_plus4_m_d;
            rd_m_q         <= rd_m_d;
            funct3_m_q     <= funct3_m_d;
        end
    end

    assign ValidM     = valid_m_q;
    assign RegWriteM  = reg_write_m_q;
    assign MemWriteM  = mem_write_m_q;
    assign ResultSrcM = result_src_m_q;
    assign ALUResultM = alu_result_m_q;
    assign WriteDataM = write_data_m_q;
    assign PCPlus4M   = pc_plus4_m_q;
    assign RdM        = rd_m_q;
    assign funct3M    = funct3_m_q;

endmodule

// File: tb/tb_stage3_ex.sv
// Randomized + directed bench for stage3_ex against a behavioural model.
// Multiplier checks are compiled in when RV32_MUL_EN is defined.
module tb_stage3_ex;

    logic        clk = 1'b0;
    logic        rst;
    logic        ValidE, RegWriteE, MemWriteE, ALUSrcE, BranchE, JumpE, JalrE, StallM;
    logic [1:0]  ResultSrcE, ForwardAE, ForwardBE;
    logic [3:0]  ALUctrlE;
    logic [31:0] RD1E, RD2E, ImmExtE, pce, ResultW;
    logic [4:0]  RdE;
    logic [2:0]  funct3E;
    logic        PCSrcE, BusyE, ValidM, RegWriteM, MemWriteM;
    logic [31:0] PCTargetE, ALUResultM, WriteDataM, PCPlus4M;
    logic [1:0]  ResultSrcM;
    logic [4:0]  RdM;
    logic [2:0]  funct3M;

    int checks = 0;
    int errors = 0;

    // Model of the EX/MEM register contents.
    logic        m_valid, m_regw, m_memw;
    logic [1:0]  m_rsrc;
    logic [31:0] m_alu, m_wd, m_pc4;
    logic [4:0]  m_rd;
    logic [2:0]  m_f3;

    stage3_ex #(
        .DATA_WIDTH     (32),
        .RESET_PC_TARGET(32'h0)
    ) dut (
        .clk(clk), .rst(rst), .ValidE(ValidE), .RegWriteE(RegWriteE),
        .ResultSrcE(ResultSrcE), .MemWriteE(MemWriteE), .ALUctrlE(ALUctrlE),
        .ALUSrcE(ALUSrcE), .BranchE(BranchE), .JumpE(JumpE), .JalrE(JalrE),
        .RD1E(RD1E), .RD2E(RD2E), .RdE(RdE), .ImmExtE(ImmExtE), .pce(pce),
        .funct3E(funct3E), .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ResultW(ResultW), .StallM(StallM), .PCSrcE(PCSrcE), .PCTargetE(PCTargetE),
        .BusyE(BusyE), .ValidM(ValidM), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
        .ResultSrcM(ResultSrcM), .ALUResultM(ALUResultM), .WriteDataM(WriteDataM),
        .PCPlus4M(PCPlus4M), .RdM(RdM), .funct3M(funct3M)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic model_clear();
        m_valid = 0; m_regw = 0; m_memw = 0; m_rsrc = 0;
        m_alu = 0; m_wd = 0; m_pc4 = 0; m_rd = 0; m_f3 = 0;
    endtask

    task automatic clear_ins();
        rst = 0; ValidE = 0; RegWriteE = 0; MemWriteE = 0; ALUSrcE = 0; BranchE = 0;
        JumpE = 0; JalrE = 0; StallM = 0; ResultSrcE = 0; ForwardAE = 0; ForwardBE = 0;
        ALUctrlE = 0; RD1E = 0; RD2E = 0; ImmExtE = 0; pce = 0; ResultW = 0; RdE = 0;
        funct3E = 0;
    endtask

    function automatic logic [31:0] fwd_ref(input logic [31:0] rf, input logic [1:0] sel,
                                            input logic [31:0] wb, input logic [31:0] mem);
        if (sel == 2'd1) return wb;
        if (sel == 2'd2) return mem;
        return rf;
    endfunction

    function automatic logic [31:0] alu_ref(input int op, input logic [31:0] a, input logic [31:0] b);
        int unsigned sh;
        logic [31:0] r;
        sh = b % 32;
        case (op)
            0:  return a + b;
            1:  return a + (~b + 1);
            2:  return a & b;
            3:  return a | b;
            4:  return a ^ b;
            5:  return (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            6:  return (a < b) ? 32'd1 : 32'd0;
            7:  return a << sh;
            8:  return a >> sh;
            9: begin
                r = a >> sh;
                if (a[31]) r = r | ~(32'hFFFF_FFFF >> sh);
                return r;
            end
            10: return b;
            default: return 32'd0;
        endcase
    endfunction

    function automatic bit taken_ref(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'd0: return a == b;
            3'd1: return a != b;
            3'd4: return int'(a) <  int'(b);
            3'd5: return int'(a) >= int'(b);
            3'd6: return a <  b;
            3'd7: return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    // One clock with the current inputs: check redirect/busy, advance model, check EX/MEM.
    task automatic step();
        logic [31:0] a, wd, b, alu, tgt;
        bit pcs;
        #1;
        a   = fwd_ref(RD1E, ForwardAE, ResultW, m_alu);
        wd  = fwd_ref(RD2E, ForwardBE, ResultW, m_alu);
        b   = ALUSrcE ? ImmExtE : wd;
        alu = alu_ref(int'(ALUctrlE), a, b);
        pcs = ValidE && (JumpE || (BranchE && taken_ref(funct3E, a, b)));
        tgt = !ValidE ? 32'h0 : (JalrE ? (alu & 32'hFFFF_FFFE) : pce + ImmExtE);
        check("PCSrcE", 32'(PCSrcE), 32'(pcs));
        check("PCTargetE", PCTargetE, tgt);
        check("BusyE", 32'(BusyE), 32'd0);
        @(posedge clk);
        if (rst) begin
            model_clear();
        end else if (!StallM) begin
            m_valid = ValidE; m_regw = RegWriteE & ValidE; m_memw = MemWriteE & ValidE;
            m_rsrc = ResultSrcE; m_alu = alu; m_wd = wd; m_pc4 = pce + 32'd4;
            m_rd = RdE; m_f3 = funct3E;
        end
        #1;
        check("ValidM", 32'(ValidM), 32'(m_valid));
        check("RegWriteM", 32'(RegWriteM), 32'(m_regw));
        check("MemWriteM", 32'(MemWriteM), 32'(m_memw));
        check("ResultSrcM", 32'(ResultSrcM), 32'(m_rsrc));
        check("ALUResultM", ALUResultM, m_alu);
        check("WriteDataM", WriteDataM, m_wd);
        check("PCPlus4M", PCPlus4M, m_pc4);
        check("RdM", 32'(RdM), 32'(m_rd));
        check("funct3M", 32'(funct3M), 32'(m_f3));
        @(negedge clk);
    endtask

    initial begin
        int unsigned op;
        clear_ins();
        model_clear();
        rst = 1;
        @(negedge clk);

        // Reset for two cycles.
        step();
        step();
        check("rst_validm", 32'(ValidM), 32'd0);
        check("rst_alum", ALUResultM, 32'd0);
        check("rst_busy", 32'(BusyE), 32'd0);
        rst = 0;

        // ADD 5 + 7.
        ValidE = 1; RegWriteE = 1; ALUctrlE = 4'd0; RD1E = 5; RD2E = 7; RdE = 5'd3;
        step();
        check("add_res", ALUResultM, 32'd12);
        check("add_valid", 32'(ValidM), 32'd1);

        // Forwarding: prime ALUResultM=100, then SUB from MEM and WB paths.
        RD1E = 100; RD2E = 0;
        step();
        RD1E = 1; ForwardAE = 2'b10; ALUctrlE = 4'd1; ALUSrcE = 1; ImmExtE = 30;
        step();
        check("fwd_mem", ALUResultM, 32'd70);
        ForwardAE = 2'b01; ResultW = 9;
        step();
        check("fwd_wb", ALUResultM, 32'hFFFF_FFEB);
        ForwardAE = 0; ALUSrcE = 0;

        // Branches: BLT taken, BLTU not taken, then JALR.
        RegWriteE = 0; BranchE = 1; funct3E = 3'b100; RD1E = 32'hFFFF_FFFF; RD2E = 1;
        pce = 32'h100; ImmExtE = 32'h20;
        #1;
        check("blt_src", 32'(PCSrcE), 32'd1);
        check("blt_tgt", PCTargetE, 32'h120);
        step();
        funct3E = 3'b110;
        #1;
        check("bltu_src", 32'(PCSrcE), 32'd0);
        step();
        BranchE = 0; JumpE = 1; JalrE = 1; RegWriteE = 1; ResultSrcE = 2'b10;
        ALUctrlE = 4'd0; ALUSrcE = 1; RD1E = 32'h203; ImmExtE = 0; pce = 32'h400;
        #1;
        check("jalr_tgt", PCTargetE, 32'h202);
        step();
        check("jalr_pc4", PCPlus4M, 32'h404);
        JumpE = 0; JalrE = 0; ResultSrcE = 0; ALUSrcE = 0;

        // Stall across an ADD issue: outputs hold, then update on release.
        RD1E = 40; RD2E = 2;
        StallM = 1;
        step(); step(); step();
        check("stall_hold", PCPlus4M, 32'h404);
        StallM = 0;
        step();
        check("stall_rel", ALUResultM, 32'd42);

        // Bubble: write enables and jump ignored.
        ValidE = 0; RegWriteE = 1; MemWriteE = 1; JumpE = 1;
        #1;
        check("bub_pcsrc", 32'(PCSrcE), 32'd0);
        step();
        check("bub_regw", 32'(RegWriteM), 32'd0);
        check("bub_memw", 32'(MemWriteM), 32'd0);
        JumpE = 0;

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 99) < 2);
            StallM = ($urandom_range(0, 99) < 15);
            ValidE = ($urandom_range(0, 99) < 80);
`ifdef RV32_MUL_EN
            do op = $urandom_range(0, 15); while (op == 11);
`else
            op = $urandom_range(0, 15);
`endif
            ALUctrlE = 4'(op);
            RegWriteE = 1'($urandom); MemWriteE = 1'($urandom); ALUSrcE = 1'($urandom);
            BranchE = 1'($urandom); JumpE = ($urandom_range(0, 9) == 0); JalrE = 1'($urandom);
            ResultSrcE = 2'($urandom_range(0, 2));
            RD1E = $urandom; RD2E = ($urandom_range(0, 3) == 0) ? RD1E : $urandom;
            ImmExtE = $urandom; pce = $urandom; ResultW = $urandom;
            RdE = 5'($urandom); funct3E = 3'($urandom);
            ForwardAE = 2'($urandom); ForwardBE = 2'($urandom);
            step();
        end

`ifdef RV32_MUL_EN
        // Multiplier: 0xFFFF * 0x10001, operands captured at issue.
        clear_ins();
        rst = 1;
        step();
        rst = 0;
        ValidE = 1; RegWriteE = 1; ALUctrlE = 4'd11; RD1E = 32'hFFFF; RD2E = 32'h10001; RdE = 5'd9;
        #1;
        check("mul_issue_busy", 32'(BusyE), 32'd1);
        for (int c = 1; c <= 32; c++) begin
            @(posedge clk); #1;
            check("mul_busy", 32'(BusyE), 32'd1);
            check("mul_validm", 32'(ValidM), 32'd0);
            @(negedge clk);
            ForwardAE = 2'b01; ForwardBE = 2'b01; ResultW = $urandom;
        end
        @(posedge clk); #1;
        check("mul_done_busy", 32'(BusyE), 32'd0);
        @(posedge clk); #1;
        check("mul_product", ALUResultM, 32'hFFFF_FFFF);
        check("mul_valid", 32'(ValidM), 32'd1);
        check("mul_rd", 32'(RdM), 32'd9);
        @(negedge clk);

        // Reset mid-operation.
        clear_ins();
        ValidE = 1; ALUctrlE = 4'd11; RD1E = 3; RD2E = 5;
        for (int c = 0; c < 10; c++) @(negedge clk);
        ValidE = 0; rst = 1;
        @(posedge clk); #1;
        check("mul_rst_busy", 32'(BusyE), 32'd0);
        @(negedge clk);
        rst = 0;
        #1;
        check("mul_rst_idle", 32'(BusyE), 32'd0);
        model_clear();
        ValidE = 1; ALUctrlE = 4'd0; RD1E = 20; RD2E = 22;
        step();
        check("mul_after_rst", ALUResultM, 32'd42);
`else
        // Without the multiplier, opcode 1011 yields 0 and never stalls.
        clear_ins();
        ValidE = 1; ALUctrlE = 4'd11; RD1E = 6; RD2E = 7;
        #1;
        check("mul_off_busy", 32'(BusyE), 32'd0);
        step();
        check("mul_off_res", ALUResultM, 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
